// File: rtl/bytebeat_pkg.sv
// Shared definitions for the bytebeat audio path (generator and PWM DAC).
//   PCM_W    : PCM sample width in bits
//   pcm_t    : one unsigned PCM sample
//   MIDSCALE : silent level (half scale), used as the power-up sample
package bytebeat_pkg;

  localparam int PCM_W = 8;

  typedef logic [PCM_W-1:0] pcm_t;

  localparam pcm_t MIDSCALE = pcm_t'(1 << (PCM_W - 1));

endpackage

// File: rtl/bytebeat_pwm_dac_pwm_core.sv
// Free-running PWM frame generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : low holds the frame counter and output at zero
//   active     : duty value; the output is high for `active` clocks per frame
//   pwm_out    : registered PWM output
//   frame_end  : high during the last clock of each frame (combinational)
module pwm_core
  import bytebeat_pkg::*;
#(
  parameter int PCM_W = bytebeat_pkg::PCM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PCM_W-1:0] active,
  output logic             pwm_out,
  output logic             frame_end
);

  logic [PCM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_out_q, pwm_out_d;

  // Disabling forces the counter to frame start so that re-enabling begins
  // on a clean frame boundary.
  always_comb begin
    pwm_cnt_d = '0;
    pwm_out_d = 1'b0;
    if (ena) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      pwm_out_d = (pwm_cnt_q < active);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out   = pwm_out_q;
  assign frame_end = ena && (pwm_cnt_q == '1);

endmodule

// File: rtl/bytebeat_pwm_dac.sv
// PWM audio DAC stage for the bytebeat generator.
// Buffers one pending sample behind the active one; the active sample sets
// the duty of a 2^PCM_W-clock PWM frame and is replaced every
// (sample_period+1) frames.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ena           : low freezes PWM generation (handshake keeps working)
//   pcm_in        : unsigned sample, qualified by pcm_in_vld
//   pcm_in_rdy    : registered ready, high while the pending slot is empty
//   sample_period : PWM frames per sample minus one
//   underrun_clr  : clears the sticky underrun flag
//   pwm_out       : registered PWM output
//   sample_strobe : one-cycle pulse when a new sample becomes active
//   underrun      : sticky, set when a sample was due but none was pending
module bytebeat_pwm_dac
  import bytebeat_pkg::*;
#(
  parameter int PCM_W = bytebeat_pkg::PCM_W,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PCM_W-1:0] pcm_in,
  input  logic             pcm_in_vld,
  output logic             pcm_in_rdy,
  input  logic [REP_W-1:0] sample_period,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             sample_strobe,
  output logic             underrun
);

  // Half scale, so power-up produces no audible step.
  localparam logic [PCM_W-1:0] ACTIVE_RST = {1'b1, {(PCM_W-1){1'b0}}};

  logic [PCM_W-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [PCM_W-1:0] active_q, active_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rdy_q, rdy_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic frame_end;
  logic accept;
  logic boundary;

  pwm_core #(
    .PCM_W (PCM_W)
  ) u_pwm_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .active    (active_q),
    .pwm_out   (pwm_out),
    .frame_end (frame_end)
  );

  assign accept = pcm_in_vld && rdy_q;

  // '>=' rather than '==' so a mid-run decrease of sample_period takes
  // effect at the next frame end instead of after a counter wrap.
  assign boundary = frame_end && (rep_cnt_q >= sample_period);

  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    rep_cnt_d   = rep_cnt_q;
    strobe_d    = 1'b0;
    underrun_d  = underrun_q;

    if (!ena) begin
      rep_cnt_d = '0;
    end else if (boundary) begin
      rep_cnt_d = '0;
    end else if (frame_end) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end

    // Promotion and accept never collide: accept needs an empty slot, and
    // promotion needs a full one.
    if (boundary && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
      strobe_d    = 1'b1;
    end else if (accept) begin
      pend_d      = pcm_in;
      pend_full_d = 1'b1;
    end

    // A fresh underrun outranks a simultaneous clear.
    if (boundary && !pend_full_q) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    rdy_d = !pend_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      active_q    <= ACTIVE_RST;
      rep_cnt_q   <= '0;
      rdy_q       <= 1'b1;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      rep_cnt_q   <= rep_cnt_d;
      rdy_q       <= rdy_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pcm_in_rdy    = rdy_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_bytebeat_pwm_dac.sv
module tb_bytebeat_pwm_dac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] pcm_in = '0;
  logic       pcm_in_vld = 1'b0;
  logic       pcm_in_rdy;
  logic [3:0] sample_period = '0;
  logic       underrun_clr = 1'b0;
  logic       pwm_out;
  logic       sample_strobe;
  logic       underrun;
  logic [3:0] dut_vec;

  int n_chk = 0;
  int n_err = 0;

  bytebeat_pwm_dac #(.PCM_W(8), .REP_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .pcm_in        (pcm_in),
    .pcm_in_vld    (pcm_in_vld),
    .pcm_in_rdy    (pcm_in_rdy),
    .sample_period (sample_period),
    .underrun_clr  (underrun_clr),
    .pwm_out       (pwm_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pwm_out, sample_strobe, underrun, pcm_in_rdy};

  // Behavioural reference: frame position and frame count as integers,
  // the pending slot as a queue of at most one sample.
  int         m_pos = 0;
  int         m_rep = 0;
  logic [7:0] m_active = 8'h80;
  logic [7:0] m_pend[$];
  bit         m_pwm = 1'b0;
  bit         m_strobe = 1'b0;
  bit         m_under = 1'b0;
  bit         m_acc;
  bit         m_bnd;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0; m_rep = 0; m_pend.delete(); m_active = 8'h80;
      m_pwm = 1'b0; m_strobe = 1'b0; m_under = 1'b0;
    end else begin
      m_acc = pcm_in_vld && (m_pend.size() == 0);
      m_bnd = ena && (m_pos == 255) && (m_rep >= int'(sample_period));
      m_pwm = ena && (m_pos < int'(m_active));
      m_strobe = m_bnd && (m_pend.size() != 0);
      if (m_bnd && m_pend.size() == 0) m_under = 1'b1;
      else if (underrun_clr) m_under = 1'b0;
      if (m_strobe) m_active = m_pend.pop_front();
      if (m_acc) m_pend.push_back(pcm_in);
      if (!ena) begin
        m_pos = 0; m_rep = 0;
      end else begin
        if (m_bnd) m_rep = 0;
        else if (m_pos == 255) m_rep = m_rep + 1;
        m_pos = (m_pos + 1) % 256;
      end
    end
  end

  function automatic logic [3:0] m_vec();
    return {m_pwm, m_strobe, m_under, m_pend.size() == 0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1; pcm_in_vld = 1'b0; pcm_in = '0; sample_period = '0; underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int hi = 0;
    int strobes = 0;
    do_reset();
    n_chk++; if (dut_vec !== 4'b0001) begin n_err++; $display("FAIL reset_state got %b want 0001", dut_vec); end
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(pwm_out); strobes += int'(sample_strobe);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL reset_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 255) begin n_chk++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun_early got %b want 0", underrun); end end
      if (i == 256) begin n_chk++; if (underrun !== 1'b1) begin n_err++; $display("FAIL reset_underrun_set got %b want 1", underrun); end end
    end
    n_chk++; if (hi != 128) begin n_err++; $display("FAIL reset_duty got %0d want 128", hi); end
    n_chk++; if (strobes != 0) begin n_err++; $display("FAIL reset_strobes got %0d want 0", strobes); end
  endtask

  task automatic test_push();
    int hi = 0;
    do_reset();
    for (int i = 1; i <= 512; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL push_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 5) begin pcm_in = 8'h40; pcm_in_vld = 1'b1; end
      if (i == 6) begin
        n_chk++; if (pcm_in_rdy !== 1'b0) begin n_err++; $display("FAIL push_rdy_low got %b want 0", pcm_in_rdy); end
        pcm_in_vld = 1'b0;
      end
      if (i == 256) begin
        n_chk++; if ({sample_strobe, pcm_in_rdy} !== 2'b11) begin n_err++; $display("FAIL push_strobe_rdy got %b want 11", {sample_strobe, pcm_in_rdy}); end
      end
      if (i > 256) hi += int'(pwm_out);
    end
    n_chk++; if (hi != 64) begin n_err++; $display("FAIL push_duty got %0d want 64", hi); end
  endtask

  task automatic test_extremes();
    int hi0 = 0;
    int hif = 0;
    do_reset();
    pcm_in = 8'h00; pcm_in_vld = 1'b1;
    for (int i = 1; i <= 768; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL ext_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 1) begin
        n_chk++; if (pcm_in_rdy !== 1'b0) begin n_err++; $display("FAIL ext_accept0 got %b want 0", pcm_in_rdy); end
        pcm_in = 8'hFF;
      end
      if (i == 256 || i == 512) begin
        n_chk++; if (sample_strobe !== 1'b1) begin n_err++; $display("FAIL ext_strobe c%0d got %b want 1", i, sample_strobe); end
      end
      if (i == 257) begin
        n_chk++; if (pcm_in_rdy !== 1'b0) begin n_err++; $display("FAIL ext_acceptff got %b want 0", pcm_in_rdy); end
        pcm_in_vld = 1'b0;
      end
      if (i > 256 && i <= 512) hi0 += int'(pwm_out);
      if (i > 512) hif += int'(pwm_out);
    end
    n_chk++; if (hi0 != 0) begin n_err++; $display("FAIL ext_duty00 got %0d want 0", hi0); end
    n_chk++; if (hif != 255) begin n_err++; $display("FAIL ext_dutyff got %0d want 255", hif); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] cur_val = '0;
    bit have_val = 1'b0;
    bit will_acc;
    int strobes = 0, last_k = 0, acc_hi = 0, rdy_lo = 0;
    do_reset();
    sample_period = 4'd3;
    pcm_in = 8'($urandom);
    pcm_in_vld = 1'b1;
    will_acc = 1'b1;
    exp_q.push_back(pcm_in);
    for (int i = 1; i <= 6148; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL b2b_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      acc_hi += int'(pwm_out);
      rdy_lo += int'(!pcm_in_rdy);
      if (sample_strobe === 1'b1) begin
        strobes++;
        if (have_val) begin
          n_chk++; if (i - last_k != 1024) begin n_err++; $display("FAIL b2b_interval got %0d want 1024", i - last_k); end
          n_chk++; if (acc_hi != 4 * int'(cur_val)) begin n_err++; $display("FAIL b2b_value got %0d want %0d", acc_hi, 4 * int'(cur_val)); end
          n_chk++; if (rdy_lo != 1023) begin n_err++; $display("FAIL b2b_rdy_low got %0d want 1023", rdy_lo); end
        end
        n_chk++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_order got strobe want no strobe (nothing accepted)"); end
        else begin cur_val = exp_q.pop_front(); have_val = 1'b1; end
        last_k = i; acc_hi = 0; rdy_lo = 0;
      end
      if (will_acc) pcm_in = pcm_in + 8'd1;
      will_acc = (m_pend.size() == 0);
      if (will_acc) exp_q.push_back(pcm_in);
    end
    pcm_in_vld = 1'b0;
    n_chk++; if (strobes != 6) begin n_err++; $display("FAIL b2b_strobes got %0d want 6", strobes); end
  endtask

  task automatic test_underrun();
    logic [7:0] v;
    int h1 = 0, h2 = 0;
    do_reset();
    v = 8'($urandom_range(1, 254));
    pcm_in = v; pcm_in_vld = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL und_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 1) pcm_in_vld = 1'b0;
      if (i == 511) begin n_chk++; if (underrun !== 1'b0) begin n_err++; $display("FAIL und_early got %b want 0", underrun); end end
      if (i == 512) begin n_chk++; if (underrun !== 1'b1) begin n_err++; $display("FAIL und_set got %b want 1", underrun); end end
      if (i == 767) underrun_clr = 1'b1;
      if (i == 768) begin
        n_chk++; if (underrun !== 1'b1) begin n_err++; $display("FAIL und_set_wins got %b want 1", underrun); end
        underrun_clr = 1'b0;
      end
      if (i == 800) underrun_clr = 1'b1;
      if (i == 801) begin
        n_chk++; if (underrun !== 1'b0) begin n_err++; $display("FAIL und_clear got %b want 0", underrun); end
        underrun_clr = 1'b0;
      end
      if (i > 512 && i <= 768) h1 += int'(pwm_out);
      if (i > 768) h2 += int'(pwm_out);
    end
    n_chk++; if (h1 != int'(v)) begin n_err++; $display("FAIL und_held1 got %0d want %0d", h1, v); end
    n_chk++; if (h2 != int'(v)) begin n_err++; $display("FAIL und_held2 got %0d want %0d", h2, v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    int hi = 0;
    do_reset();
    v = 8'($urandom_range(8'h90, 8'hFF));
    pcm_in = v; pcm_in_vld = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL arst_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 1) pcm_in_vld = 1'b0;
      if (i == 520) begin pcm_in = 8'($urandom); pcm_in_vld = 1'b1; end
      if (i == 521) pcm_in_vld = 1'b0;
    end
    n_chk++; if (dut_vec !== 4'b1010) begin n_err++; $display("FAIL arst_before got %b want 1010", dut_vec); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (dut_vec !== 4'b0001) begin n_err++; $display("FAIL arst_immediate got %b want 0001", dut_vec); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL arst_after c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 256) begin n_chk++; if (underrun !== 1'b1) begin n_err++; $display("FAIL arst_pend_empty got %b want 1", underrun); end end
    end
    n_chk++; if (hi != 128) begin n_err++; $display("FAIL arst_midscale got %0d want 128", hi); end
  endtask

  task automatic test_ena();
    int hi = 0, str = 0;
    do_reset();
    ena = 1'b0;
    pcm_in = 8'($urandom); pcm_in_vld = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL ena_off c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 1) pcm_in_vld = 1'b0;
      hi += int'(pwm_out); str += int'(sample_strobe);
    end
    n_chk++; if (hi != 0 || str != 0) begin n_err++; $display("FAIL ena_frozen got hi=%0d strobes=%0d want 0 0", hi, str); end
    n_chk++; if (pcm_in_rdy !== 1'b0) begin n_err++; $display("FAIL ena_buffered got %b want 0", pcm_in_rdy); end
    ena = 1'b1;
    hi = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL ena_on c%0d got %b want %b", i, dut_vec, m_vec()); end
      if (i == 256) begin n_chk++; if (sample_strobe !== 1'b1) begin n_err++; $display("FAIL ena_strobe got %b want 1", sample_strobe); end end
    end
    n_chk++; if (hi != 128) begin n_err++; $display("FAIL ena_restart_duty got %0d want 128", hi); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec !== m_vec()) begin n_err++; $display("FAIL rand_run c%0d got %b want %b", i, dut_vec, m_vec()); end
      pcm_in_vld = ($urandom_range(0, 3) == 0);
      pcm_in = 8'($urandom);
      sample_period = 4'($urandom_range(0, 2));
      underrun_clr = ($urandom_range(0, 15) == 0);
      if (ena && $urandom_range(0, 199) == 0) ena = 1'b0;
      else if (!ena && $urandom_range(0, 19) == 0) ena = 1'b1;
    end
    ena = 1'b1; pcm_in_vld = 1'b0; underrun_clr = 1'b0; sample_period = '0;
  endtask

  initial begin
    test_reset();
    test_push();
    test_extremes();
    test_back_to_back();
    test_underrun();
    test_async_reset();
    test_ena();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
